// File: rtl/bram_mc_pkg.sv
// ----------------------------------------------------------------------
// bram_mc_pkg : shared types and limits for the BRAM multi-channel front end
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

package bram_mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_VERIFY = 3'd3,
    ST_RESP   = 3'd4
  } state_e;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 3;

  function automatic int wait_cnt_w(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ----------------------------------------------------------------------
// rr_arbiter : round-robin one-hot grant, pointer moves past the winner on advance
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module rr_arbiter #(
  parameter int NUM_CH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant
);

  if (NUM_CH == 1) begin : g_fixed
    logic unused_in;
    assign unused_in = ^{clk, rst, advance};
    assign grant     = req;
  end else begin : g_rr
    localparam int PTR_W = $clog2(NUM_CH);

    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] sel;
    logic             found;
    int               idx;

    always_comb begin
      grant = '0;
      found = 1'b0;
      sel   = ptr_q;
      idx   = 0;
      for (int k = 0; k < NUM_CH; k++) begin
        idx = (int'(ptr_q) + k) % NUM_CH;
        if (!found && req[idx]) begin
          found = 1'b1;
          sel   = PTR_W'(idx);
        end
      end
      if (found) grant[sel] = 1'b1;
      ptr_d = ptr_q;
      if (advance && found)
        ptr_d = (sel == PTR_W'(NUM_CH - 1)) ? '0 : sel + PTR_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/bram_mc_if.sv
// ----------------------------------------------------------------------
// bram_mc_if : arbitrates NUM_CH requesters onto one BRAM port, optional write readback
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module bram_mc_if
  import bram_mc_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int WR_VERIFY = 1
) (
  input  logic                       axi_clk,
  input  logic                       axi_rst,
  input  logic [NUM_CH-1:0]          req_valid,
  output logic [NUM_CH-1:0]          req_ready,
  input  logic [NUM_CH-1:0]          req_we,
  input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
  input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
  input  logic [NUM_CH*DATA_W/8-1:0] req_be,
  output logic [NUM_CH-1:0]          rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       bram_clk,
  output logic                       bram_rst,
  output logic                       bram_en,
  output logic [DATA_W/8-1:0]        bram_we,
  output logic [ADDR_W-1:0]          bram_addr,
  output logic [DATA_W-1:0]          bram_din,
  input  logic [DATA_W-1:0]          bram_dout
);

  localparam int BE_W  = DATA_W / 8;
  localparam int LAT   = (RD_LAT < RD_LAT_MIN) ? RD_LAT_MIN :
                         (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;
  localparam int CNT_W = wait_cnt_w(LAT);

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   gnt_q, gnt_d;
  logic                lat_we_q, lat_we_d;
  logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;
  logic [BE_W-1:0]     lat_be_q, lat_be_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_CH-1:0]   req_ready_q, req_ready_d;
  logic [NUM_CH-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                bram_en_q, bram_en_d;
  logic [BE_W-1:0]     bram_we_q, bram_we_d;
  logic [ADDR_W-1:0]   bram_addr_q, bram_addr_d;
  logic [DATA_W-1:0]   bram_din_q, bram_din_d;

  logic [NUM_CH-1:0]   arb_grant;
  logic                arb_advance;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [BE_W-1:0]     sel_be;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk     (axi_clk),
    .rst     (axi_rst),
    .req     (req_valid),
    .advance (arb_advance),
    .grant   (arb_grant)
  );

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (arb_grant[i]) begin
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
        sel_be    = req_be[i*BE_W +: BE_W];
      end
    end
  end

  // Each state computes the registered outputs seen one cycle later on the pins.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    lat_be_d    = lat_be_q;
    cnt_d       = cnt_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    bram_en_d   = 1'b0;
    bram_we_d   = '0;
    bram_addr_d = bram_addr_q;
    bram_din_d  = bram_din_q;
    arb_advance = 1'b0;

    case (state_q)
      ST_ISSUE: begin
        bram_en_d   = 1'b1;
        bram_we_d   = lat_we_q ? lat_be_q : '0;
        bram_addr_d = lat_addr_q;
        bram_din_d  = lat_wdata_q;
        cnt_d       = '0;
        if (!lat_we_q)           state_d = ST_WAIT;
        else if (WR_VERIFY != 0) state_d = ST_VERIFY;
        else                     state_d = ST_RESP;
      end
      ST_VERIFY: begin
        bram_en_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(LAT - 1)) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid_d = gnt_q;
        if (!lat_we_q || (WR_VERIFY != 0)) rsp_rdata_d = bram_dout;
        state_d = ST_IDLE;
      end
      default: ;
    endcase

    // RESP doubles as an arbitration slot so back-to-back requests lose no cycle.
    if ((state_q == ST_IDLE || state_q == ST_RESP) && (|arb_grant)) begin
      arb_advance = 1'b1;
      req_ready_d = arb_grant;
      gnt_d       = arb_grant;
      lat_we_d    = sel_we;
      lat_addr_d  = sel_addr;
      lat_wdata_d = sel_wdata;
      lat_be_d    = sel_be;
      state_d     = ST_ISSUE;
    end
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      lat_be_q    <= '0;
      cnt_q       <= '0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      bram_en_q   <= 1'b0;
      bram_we_q   <= '0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_be_q    <= lat_be_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      bram_en_q   <= bram_en_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign bram_en   = bram_en_q;
  assign bram_we   = bram_we_q;
  assign bram_addr = bram_addr_q;
  assign bram_din  = bram_din_q;
  assign bram_clk  = axi_clk;
  assign bram_rst  = axi_rst;

endmodule

`default_nettype wire

// File: tb/tb_bram_mc_if.sv
// ----------------------------------------------------------------------
// tb_bram_mc_if : directed bench for bram_mc_if (RD_LAT=1/verify and RD_LAT=3/no-verify)
// Rev 1.0
// ----------------------------------------------------------------------
`default_nettype none

module tb_bram_mc_if;

  logic axi_clk = 1'b0;
  logic axi_rst;
  always #5 axi_clk = ~axi_clk;

  int checks   = 0;
  int failures = 0;

  // Instance 1: RD_LAT=1, WR_VERIFY=1
  logic [1:0]  r1_valid, r1_we, o1_ready, o1_rsp;
  logic [63:0] r1_addr, r1_wdata;
  logic [7:0]  r1_be;
  logic [31:0] o1_rdata, b1_addr, b1_din, b1_dout;
  logic        b1_clk, b1_rst, b1_en;
  logic [3:0]  b1_we;

  // Instance 3: RD_LAT=3, WR_VERIFY=0
  logic [1:0]  r3_valid, r3_we, o3_ready, o3_rsp;
  logic [63:0] r3_addr, r3_wdata;
  logic [7:0]  r3_be;
  logic [31:0] o3_rdata, b3_addr, b3_din, b3_dout;
  logic        b3_clk, b3_rst, b3_en;
  logic [3:0]  b3_we;

  bram_mc_if #(.NUM_CH(2), .DATA_W(32), .ADDR_W(32), .RD_LAT(1), .WR_VERIFY(1)) u_dut1 (
    .axi_clk(axi_clk), .axi_rst(axi_rst),
    .req_valid(r1_valid), .req_ready(o1_ready), .req_we(r1_we),
    .req_addr(r1_addr), .req_wdata(r1_wdata), .req_be(r1_be),
    .rsp_valid(o1_rsp), .rsp_rdata(o1_rdata),
    .bram_clk(b1_clk), .bram_rst(b1_rst), .bram_en(b1_en), .bram_we(b1_we),
    .bram_addr(b1_addr), .bram_din(b1_din), .bram_dout(b1_dout)
  );

  bram_mc_if #(.NUM_CH(2), .DATA_W(32), .ADDR_W(32), .RD_LAT(3), .WR_VERIFY(0)) u_dut3 (
    .axi_clk(axi_clk), .axi_rst(axi_rst),
    .req_valid(r3_valid), .req_ready(o3_ready), .req_we(r3_we),
    .req_addr(r3_addr), .req_wdata(r3_wdata), .req_be(r3_be),
    .rsp_valid(o3_rsp), .rsp_rdata(o3_rdata),
    .bram_clk(b3_clk), .bram_rst(b3_rst), .bram_en(b3_en), .bram_we(b3_we),
    .bram_addr(b3_addr), .bram_din(b3_din), .bram_dout(b3_dout)
  );

  // BRAM models; contents preloaded while reset is held
  logic [31:0] mem1 [0:255];
  logic [31:0] mem3 [0:255];
  logic [31:0] p1, p3a, p3b, p3c;

  always @(posedge b1_clk) begin
    if (b1_rst) begin
      mem1[8'h10] <= 32'hCAFEF00D;
      mem1[8'h20] <= 32'hFFFFFFFF;
      p1          <= 32'h0;
    end else if (b1_en) begin
      if (b1_we == 4'b0) p1 <= mem1[b1_addr[7:0]];
      for (int b = 0; b < 4; b++)
        if (b1_we[b]) mem1[b1_addr[7:0]][8*b +: 8] <= b1_din[8*b +: 8];
    end
  end
  assign b1_dout = p1;

  always @(posedge b3_clk) begin
    if (b3_rst) begin
      mem3[8'h30] <= 32'h12345678;
      mem3[8'h40] <= 32'h0;
      p3a <= 32'h0;
      p3b <= 32'h0;
      p3c <= 32'h0;
    end else begin
      if (b3_en && b3_we == 4'b0) p3a <= mem3[b3_addr[7:0]];
      for (int b = 0; b < 4; b++)
        if (b3_en && b3_we[b]) mem3[b3_addr[7:0]][8*b +: 8] <= b3_din[8*b +: 8];
      p3b <= p3a;
      p3c <= p3b;
    end
  end
  assign b3_dout = p3c;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge axi_clk);
  endtask

  int          n;
  int          en_cnt;
  logic [1:0]  prev;
  logic [1:0]  g [4];

  initial begin
    axi_rst = 1'b1;
    r1_valid = '0; r1_we = '0; r1_addr = '0; r1_wdata = '0; r1_be = '0;
    r3_valid = '0; r3_we = '0; r3_addr = '0; r3_wdata = '0; r3_be = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_ready",  o1_ready, 2'b00);
    chk("rst_rsp",    o1_rsp,   2'b00);
    chk("rst_en",     b1_en,    1'b0);
    chk("rst_we",     b1_we,    4'h0);
    chk("rst_addr",   b1_addr,  32'h0);
    chk("rst_din",    b1_din,   32'h0);
    chk("rst_rdata",  o1_rdata, 32'h0);
    chk("rst_brst",   b1_rst,   1'b1);
    axi_rst = 1'b0;

    // Ch0 read of 0x10, RD_LAT=1
    r1_valid = 2'b01; r1_we = 2'b00; r1_addr[31:0] = 32'h10;
    tick();
    chk("s1_ready", o1_ready, 2'b01);
    chk("s1_en_T",  b1_en,    1'b0);
    r1_valid = 2'b00;
    tick();
    chk("s1_en",    b1_en,   1'b1);
    chk("s1_we",    b1_we,   4'h0);
    chk("s1_addr",  b1_addr, 32'h10);
    tick();
    chk("s1_en_off",    b1_en,  1'b0);
    chk("s1_rsp_early", o1_rsp, 2'b00);
    tick();
    chk("s1_rsp",   o1_rsp,   2'b01);
    chk("s1_rdata", o1_rdata, 32'hCAFEF00D);
    tick();
    chk("s1_rsp_pulse", o1_rsp,   2'b00);
    chk("s1_rdata_hold", o1_rdata, 32'hCAFEF00D);

    // Ch1 partial write with readback
    r1_valid = 2'b10; r1_we = 2'b10;
    r1_addr[63:32] = 32'h20; r1_wdata[63:32] = 32'hA5A5A5A5; r1_be[7:4] = 4'b0011;
    tick();
    chk("s2_ready", o1_ready, 2'b10);
    r1_valid = 2'b00; r1_we = 2'b00;
    tick();
    chk("s2_en",   b1_en,   1'b1);
    chk("s2_we",   b1_we,   4'b0011);
    chk("s2_addr", b1_addr, 32'h20);
    chk("s2_din",  b1_din,  32'hA5A5A5A5);
    tick();
    chk("s2_ver_en",   b1_en,   1'b1);
    chk("s2_ver_we",   b1_we,   4'h0);
    chk("s2_ver_addr", b1_addr, 32'h20);
    tick();
    chk("s2_en_off",    b1_en,  1'b0);
    chk("s2_rsp_early", o1_rsp, 2'b00);
    tick();
    chk("s2_rsp",   o1_rsp,   2'b10);
    chk("s2_rdata", o1_rdata, 32'hFFFFA5A5);

    // Both channels requesting continuously
    r1_addr[31:0] = 32'h10; r1_addr[63:32] = 32'h20; r1_we = 2'b00; r1_valid = 2'b11;
    n = 0; prev = 2'b00;
    for (int k = 0; k < 14; k++) begin
      tick();
      if (o1_ready != 2'b00) begin
        if (n > 0) chk("s3_rsp_with_grant", o1_rsp, prev);
        if (n < 4) g[n] = o1_ready;
        prev = o1_ready;
        n++;
      end
    end
    r1_valid = 2'b00;
    chk("s3_ngrants", n >= 4, 1'b1);
    chk("s3_g0", g[0], 2'b01);
    chk("s3_g1", g[1], 2'b10);
    chk("s3_g2", g[2], 2'b01);
    chk("s3_g3", g[3], 2'b10);
    repeat (4) tick();

    // RD_LAT=3 read
    r3_valid = 2'b01; r3_we = 2'b00; r3_addr[31:0] = 32'h30;
    tick();
    chk("s4_ready", o3_ready, 2'b01);
    r3_valid = 2'b00;
    en_cnt = 0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      en_cnt += int'(b3_en);
      if (k == 1) chk("s4_en", b3_en, 1'b1);
      if (k < 5) chk("s4_rsp_early", o3_rsp, 2'b00);
      else begin
        chk("s4_rsp",   o3_rsp,   2'b01);
        chk("s4_rdata", o3_rdata, 32'h12345678);
      end
    end
    chk("s4_en_cycles", en_cnt, 1);

    // Write without verify, next request accepted in the response cycle
    r3_valid = 2'b10; r3_we = 2'b10;
    r3_addr[63:32] = 32'h40; r3_wdata[63:32] = 32'h11223344; r3_be[7:4] = 4'b1111;
    tick();
    chk("s5_ready", o3_ready, 2'b10);
    r3_valid = 2'b01; r3_we = 2'b00; r3_addr[31:0] = 32'h40;
    tick();
    chk("s5_en",    b3_en,    1'b1);
    chk("s5_we",    b3_we,    4'b1111);
    chk("s5_din",   b3_din,   32'h11223344);
    chk("s5_ready_idle", o3_ready, 2'b00);
    tick();
    chk("s5_rsp",       o3_rsp,   2'b10);
    chk("s5_ready_b2b", o3_ready, 2'b01);
    chk("s5_rdata_keep", o3_rdata, 32'h12345678);
    r3_valid = 2'b00;
    repeat (4) tick();
    tick();
    chk("s5_rd_rsp",   o3_rsp,   2'b01);
    chk("s5_rd_rdata", o3_rdata, 32'h11223344);

    // Write with all byte enables clear
    r3_valid = 2'b01; r3_we = 2'b01; r3_wdata[31:0] = 32'hDEADBEEF; r3_be[3:0] = 4'b0000;
    tick();
    chk("s6_ready", o3_ready, 2'b01);
    r3_valid = 2'b00; r3_we = 2'b00;
    tick();
    chk("s6_en", b3_en, 1'b1);
    chk("s6_we", b3_we, 4'h0);
    tick();
    chk("s6_rsp",   o3_rsp,   2'b01);
    chk("s6_rdata", o3_rdata, 32'h11223344);
    chk("s6_mem",   mem3[8'h40], 32'h11223344);

    // Reset in the middle of a read
    r1_valid = 2'b01; r1_we = 2'b00; r1_addr[31:0] = 32'h10;
    tick();
    chk("s7_ready", o1_ready, 2'b01);
    r1_valid = 2'b00;
    tick();
    chk("s7_en_before", b1_en, 1'b1);
    axi_rst = 1'b1;
    #1;
    chk("s7_en",     b1_en,    1'b0);
    chk("s7_addr",   b1_addr,  32'h0);
    chk("s7_rdata",  o1_rdata, 32'h0);
    chk("s7_rdata3", o3_rdata, 32'h0);
    chk("s7_brst",   b1_rst,   1'b1);
    tick();
    chk("s7_no_rsp_a", o1_rsp, 2'b00);
    tick();
    chk("s7_no_rsp_b", o1_rsp, 2'b00);
    axi_rst = 1'b0;
    r1_addr[63:32] = 32'h20; r1_valid = 2'b11;
    tick();
    chk("s7_first_grant", o1_ready, 2'b01);
    r1_valid = 2'b00;
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
